// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target front-end that maps bus transfers onto a
// byte-wide register bank. Handles 7-bit address match, a pointer byte,
// auto-incrementing burst read/write and repeated START.
module i2c_target_regfile #(
  parameter logic [6:0] TARGET_ADDR = 7'h01,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  parameter int         FILT_LEN    = 3,
  localparam int        PW          = $clog2(NUM_REGS)
) (
  input  logic          clk_400,
  input  logic          rst_n,
  input  logic          scl_i,
  input  logic          sda_i,
  output logic          sda_oe,
  output logic          wr_en,
  output logic [PW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic [PW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          busy,
  output logic          ack_error
);

  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ADDR      = 4'd1;
  localparam logic [3:0] ADDR_ACK  = 4'd2;
  localparam logic [3:0] PTR       = 4'd3;
  localparam logic [3:0] PTR_ACK   = 4'd4;
  localparam logic [3:0] WRITE     = 4'd5;
  localparam logic [3:0] WRITE_ACK = 4'd6;
  localparam logic [3:0] READ      = 4'd7;
  localparam logic [3:0] READ_ACK  = 4'd8;

  localparam logic [8:0]    NUM_REGS_EXT = 9'(NUM_REGS);
  localparam logic [PW-1:0] PTR_LAST     = PW'(NUM_REGS - 1);

  // Pointer advance with wrap from the last register back to zero.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    if (p == PTR_LAST) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic [FILT_LEN-1:0]    scl_hist, sda_hist;
  logic [FILT_LEN-1:0]    scl_hist_next, sda_hist_next;
  logic                   scl_f, sda_f, scl_d, sda_d;
  logic                   scl_rise, scl_fall, start_ev, stop_ev;

  logic [3:0]    state;
  logic [2:0]    cnt;
  logic [7:0]    shift;
  logic          full;
  logic          mack;
  logic [PW-1:0] ptr;
  logic          ptr_ok;

  // Bring the raw pin levels into the clk_400 domain; idle bus level is high.
  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      scl_sync <= {SYNC_STAGES{1'b1}};
      sda_sync <= {SYNC_STAGES{1'b1}};
    end else begin
      scl_sync <= SYNC_STAGES'({scl_sync, scl_i});
      sda_sync <= SYNC_STAGES'({sda_sync, sda_i});
    end
  end

  // The filtered level only follows a run of FILT_LEN identical samples,
  // so it is decided from the history including the sample arriving now.
  assign scl_hist_next = FILT_LEN'({scl_hist, scl_sync[SYNC_STAGES-1]});
  assign sda_hist_next = FILT_LEN'({sda_hist, sda_sync[SYNC_STAGES-1]});

  // Glitch filter: drop any pulse shorter than FILT_LEN samples.
  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      scl_hist <= {FILT_LEN{1'b1}};
      sda_hist <= {FILT_LEN{1'b1}};
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= scl_hist_next;
      sda_hist <= sda_hist_next;
      if (&scl_hist_next) begin
        scl_f <= 1'b1;
      end else if (~|scl_hist_next) begin
        scl_f <= 1'b0;
      end
      if (&sda_hist_next) begin
        sda_f <= 1'b1;
      end else if (~|sda_hist_next) begin
        sda_f <= 1'b0;
      end
    end
  end

  // One-cycle delayed copy of the filtered lines for edge detection.
  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_ev = scl_f & scl_d & sda_d & ~sda_f;
  assign stop_ev  = scl_f & scl_d & ~sda_d & sda_f;
  assign ptr_ok   = ({1'b0, shift} < NUM_REGS_EXT);
  assign rd_addr  = ptr;

  // Protocol engine: START/STOP win over bit handling in every state;
  // SDA is only ever changed on the cycle after a filtered SCL fall.
  always_ff @(posedge clk_400) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 3'd7;
      shift     <= 8'h00;
      full      <= 1'b0;
      mack      <= 1'b0;
      ptr       <= {PW{1'b0}};
      sda_oe    <= 1'b0;
      wr_en     <= 1'b0;
      wr_addr   <= {PW{1'b0}};
      wr_data   <= 8'h00;
      busy      <= 1'b0;
      ack_error <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      if (stop_ev) begin
        state  <= IDLE;
        sda_oe <= 1'b0;
        busy   <= 1'b0;
        full   <= 1'b0;
      end else if (start_ev) begin
        // A START cutting into a read (before the controller's NACK) is an error.
        state     <= ADDR;
        sda_oe    <= 1'b0;
        cnt       <= 3'd7;
        full      <= 1'b0;
        ack_error <= (state == READ) || (state == READ_ACK);
      end else begin
        case (state)
          IDLE: begin
            sda_oe <= 1'b0;
          end
          ADDR, PTR, WRITE: begin
            if (scl_rise) begin
              shift <= {shift[6:0], sda_f};
              if (cnt == 3'd0) begin
                full <= 1'b1;
              end else begin
                cnt <= cnt - 3'd1;
              end
            end else if (scl_fall && full) begin
              full <= 1'b0;
              case (state)
                ADDR: begin
                  if (shift[7:1] == TARGET_ADDR) begin
                    busy   <= 1'b1;
                    sda_oe <= 1'b1;
                    state  <= ADDR_ACK;
                  end else begin
                    state <= IDLE;
                  end
                end
                PTR: begin
                  if (ptr_ok) begin
                    ptr    <= shift[PW-1:0];
                    sda_oe <= 1'b1;
                    state  <= PTR_ACK;
                  end else begin
                    ack_error <= 1'b1;
                    state     <= IDLE;
                  end
                end
                WRITE: begin
                  wr_en   <= 1'b1;
                  wr_addr <= ptr;
                  wr_data <= shift;
                  ptr     <= next_ptr(ptr);
                  sda_oe  <= 1'b1;
                  state   <= WRITE_ACK;
                end
                default: begin
                  state <= IDLE;
                end
              endcase
            end
          end
          ADDR_ACK: begin
            // shift[0] still holds the R/W bit of the address byte.
            if (scl_fall) begin
              cnt <= 3'd7;
              if (shift[0]) begin
                shift  <= rd_data;
                sda_oe <= ~rd_data[7];
                ptr    <= next_ptr(ptr);
                state  <= READ;
              end else begin
                sda_oe <= 1'b0;
                state  <= PTR;
              end
            end
          end
          PTR_ACK, WRITE_ACK: begin
            if (scl_fall) begin
              sda_oe <= 1'b0;
              cnt    <= 3'd7;
              state  <= WRITE;
            end
          end
          READ: begin
            if (scl_fall) begin
              if (cnt == 3'd0) begin
                sda_oe <= 1'b0;
                state  <= READ_ACK;
              end else begin
                cnt    <= cnt - 3'd1;
                shift  <= {shift[6:0], 1'b0};
                sda_oe <= ~shift[6];
              end
            end
          end
          READ_ACK: begin
            if (scl_rise) begin
              mack <= sda_f;
            end else if (scl_fall) begin
              if (!mack) begin
                shift  <= rd_data;
                sda_oe <= ~rd_data[7];
                ptr    <= next_ptr(ptr);
                cnt    <= 3'd7;
                state  <= READ;
              end else begin
                state <= IDLE;
              end
            end
          end
          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
